branch_ctrl: RTL and testbench
==============================

BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter BHT_IDX_W, default 4: branch-history-table index width; the table has 2^BHT_IDX_W entries, indexed by pc[BHT_IDX_W+1:2].
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 pc_IF  in  32  fetch-stage PC used for the prediction lookup.
REQ-005 pred_taken_IF  out  1  combinational prediction for pc_IF: the MSB of the indexed 2-bit counter.
REQ-006 valid_ID  in  1  ID stage holds a valid instruction.
REQ-007 br_type_ID  in  3  condition code: 001 EQ, 010 NE, 011 LT, 100 LTU, 101 GE, 110 GEU; 000 means not a conditional branch; 111 is reserved and treated as 000.
REQ-008 is_jal_ID  in  1  unconditional PC-relative jump; overrides br_type_ID.
REQ-009 opnd_ready_ID  in  1  rs1_data and rs2_data are final (forwarding complete).
REQ-010 rs1_data, rs2_data  in  32 each  comparison operands.
REQ-011 pc_ID, imm_ID  in  32 each  branch PC and sign-extended offset.
REQ-012 pred_taken_ID  in  1  prediction carried down with the ID instruction.
REQ-013 stall_ID  out  1  hold IF/ID; combinational.
REQ-014 redirect  out  1  registered one-cycle fetch redirect.
REQ-015 redirect_pc  out  32  registered correct next PC, valid while redirect=1.
REQ-016 flush_IF  out  1  registered; kill the instruction in IF/ID; equals redirect.
REQ-017 br_cnt, miss_cnt  out  32 each  resolved-branch count and mispredict count.

Function
REQ-018 A branch is valid_ID & (is_jal_ID | br_type_ID in 001..110).
REQ-019 FSM states: IDLE, WAIT_OPND, FLUSH.
REQ-020 IDLE: branch with opnd_ready_ID=0 -> stall_ID=1, next WAIT_OPND; branch with opnd_ready_ID=1 -> resolve this cycle.
REQ-021 WAIT_OPND: stall_ID=1 while opnd_ready_ID=0; the ID instruction is held stable; resolve in the first cycle opnd_ready_ID=1, with stall_ID=0 in that cycle.
REQ-022 Resolution: taken = is_jal_ID ? 1 : comparator result for br_type_ID on rs1_data/rs2_data, with LT/GE signed and LTU/GEU unsigned.
REQ-023 Resolution: target = taken ? pc_ID+imm_ID : pc_ID+4, mod 2^32; wrap-around is allowed.
REQ-024 Mispredict = taken XOR pred_taken_ID; on mispredict, redirect=flush_IF=1 and redirect_pc=target on the next cycle only, and the next state is FLUSH; otherwise the next state is IDLE.
REQ-025 FLUSH lasts exactly one cycle: valid_ID is ignored (the killed slot), stall_ID=0, and the next state is IDLE.
REQ-026 BHT update at the resolving edge: the indexed counter increments if taken, else decrements, saturating at 00 and 11.
REQ-027 A simultaneous BHT read and update of the same index returns the pre-update value; there is no bypass.
REQ-028 br_cnt increments by 1 per resolution and miss_cnt by 1 per mispredict; both saturate at 0xFFFF_FFFF.
REQ-029 Non-branch or invalid ID instructions cause no stall, no redirect and no BHT or counter change.

Reset
REQ-030 rst=1 at an edge: state IDLE, redirect=flush_IF=0, redirect_pc=0, br_cnt=miss_cnt=0, all BHT entries 01 (weakly not-taken).
REQ-031 While rst=1, stall_ID=0.
REQ-032 Reset asserted in the cycle a mispredict resolves, or during FLUSH, cancels the redirect: redirect=0 on the following cycle.

Structure
REQ-033 The shared package holds the br_type encodings, the FSM state enum, and the BHT reset constant 2'b01.
REQ-034 Exactly one sub-module: one instance of the existing 32-bit comparator cmp_32, with ctrl=br_type_ID.
REQ-035 The BHT is a flop array of 2^BHT_IDX_W x 2 bits; no memory macro.

Verification
REQ-036 BEQ with rs1=rs2=5, pred_taken_ID=0, pc_ID=0x100, imm=0x20, ready -> next cycle redirect=1, redirect_pc=0x120, flush_IF=1; BHT[0] 01->10; miss_cnt=1.
REQ-037 BLT with rs1=0xFFFF_FFFF, rs2=1, pred_taken_ID=1, ready -> no redirect; br_cnt=1, miss_cnt=0. BLTU with the same operands and pred_taken_ID=1 -> redirect to pc_ID+4.
REQ-038 BNE with opnd_ready_ID low for 3 cycles -> stall_ID=1 for exactly 3 cycles; resolves on cycle 4; br_cnt increments once.
REQ-039 JAL at pc_ID=0xFFFF_FFF0 with imm=0x20 and pred_taken_ID=0 -> redirect_pc=0x0000_0010.
REQ-040 Four consecutive taken resolutions at one index -> counter saturates at 11 and pred_taken_IF=1; an IF lookup in the same cycle as the 01->10 update reads 0.
REQ-041 Mispredict with rst asserted the same cycle -> redirect=0 next cycle; all counters 0; BHT entries 01.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch controller: condition-code encodings,
// FSM state type, BHT reset value and the 2-bit saturating counter update.
package branch_ctrl_pkg;

    // br_type_ID condition codes
    typedef enum logic [2:0] {
        BrNone = 3'b000,
        BrEq   = 3'b001,
        BrNe   = 3'b010,
        BrLt   = 3'b011,
        BrLtu  = 3'b100,
        BrGe   = 3'b101,
        BrGeu  = 3'b110,
        BrRsvd = 3'b111
    } br_type_e;

    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StWaitOpnd = 2'b01,
        StFlush    = 2'b10
    } br_state_e;

    // Weakly not-taken
    localparam logic [1:0] BhtReset = 2'b01;

    // Saturating 2-bit counter step: up on taken, down otherwise.
    function automatic logic [1:0] bht_next(input logic [1:0] cur, input logic taken);
        logic [1:0] nxt;
        nxt = cur;
        if (taken) begin
            if (cur != 2'b11) nxt = cur + 2'b01;
        end else begin
            if (cur != 2'b00) nxt = cur - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_ctrl_cmp.sv
// cmp_32: 32-bit branch condition comparator.
// Ports:
//   a, b    - operands
//   ctrl    - condition code (br_type_e encoding); none/reserved give 0
//   result  - condition outcome
module cmp_32
    import branch_ctrl_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  ctrl,
    output logic        result
);

    always_comb begin
        result = 1'b0;
        case (ctrl)
            BrEq:    result = (a == b);
            BrNe:    result = (a != b);
            BrLt:    result = ($signed(a) < $signed(b));
            BrLtu:   result = (a < b);
            BrGe:    result = ($signed(a) >= $signed(b));
            BrGeu:   result = (a >= b);
            default: result = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: ID-stage branch resolution with a 2-bit-counter BHT predictor.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   pc_IF / pred_taken_IF - fetch lookup PC and combinational prediction
//   valid_ID, br_type_ID, is_jal_ID, opnd_ready_ID, rs1_data, rs2_data,
//   pc_ID, imm_ID, pred_taken_ID - ID-stage branch description
//   stall_ID              - hold IF/ID while operands are not final
//   redirect, redirect_pc, flush_IF - registered one-cycle mispredict redirect
//   br_cnt, miss_cnt      - saturating resolved-branch / mispredict counters
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int unsigned BHT_IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_IF,
    output logic        pred_taken_IF,
    input  logic        valid_ID,
    input  logic [2:0]  br_type_ID,
    input  logic        is_jal_ID,
    input  logic        opnd_ready_ID,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [31:0] pc_ID,
    input  logic [31:0] imm_ID,
    input  logic        pred_taken_ID,
    output logic        stall_ID,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush_IF,
    output logic [31:0] br_cnt,
    output logic [31:0] miss_cnt
);

    localparam int unsigned NumEntries = 1 << BHT_IDX_W;

    br_state_e   state_q, state_d;
    logic [1:0]  bht_q [NumEntries];
    logic        redirect_q;
    logic [31:0] redirect_pc_q;
    logic [31:0] br_cnt_q;
    logic [31:0] miss_cnt_q;

    logic                 cmp_res;
    logic                 is_cond;
    logic                 is_branch;
    logic                 taken;
    logic                 mispredict;
    logic                 resolve;
    logic [31:0]          target;
    logic [BHT_IDX_W-1:0] rd_idx;
    logic [BHT_IDX_W-1:0] wr_idx;

    cmp_32 u_cmp (
        .a      (rs1_data),
        .b      (rs2_data),
        .ctrl   (br_type_ID),
        .result (cmp_res)
    );

    assign is_cond    = (br_type_ID != BrNone) && (br_type_ID != BrRsvd);
    assign is_branch  = valid_ID && (is_jal_ID || is_cond);
    assign taken      = is_jal_ID | cmp_res;
    assign target     = taken ? (pc_ID + imm_ID) : (pc_ID + 32'd4);
    assign mispredict = taken ^ pred_taken_ID;

    assign rd_idx = pc_IF[BHT_IDX_W+1:2];
    assign wr_idx = pc_ID[BHT_IDX_W+1:2];

    // Plain flop read: a same-cycle update of this index is not yet visible.
    assign pred_taken_IF = bht_q[rd_idx][1];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{pc_IF[31:BHT_IDX_W+2], pc_IF[1:0]};

    always_comb begin
        state_d  = state_q;
        stall_ID = 1'b0;
        resolve  = 1'b0;
        unique case (state_q)
            StIdle, StWaitOpnd: begin
                if (is_branch) begin
                    if (!opnd_ready_ID) begin
                        stall_ID = 1'b1;
                        state_d  = StWaitOpnd;
                    end else begin
                        resolve = 1'b1;
                        state_d = mispredict ? StFlush : StIdle;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            // The ID slot holds the killed instruction; ignore it.
            StFlush: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (rst) begin
            stall_ID = 1'b0;
            resolve  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
            br_cnt_q      <= 32'd0;
            miss_cnt_q    <= 32'd0;
            for (int i = 0; i < NumEntries; i++) begin
                bht_q[i] <= BhtReset;
            end
        end else begin
            state_q    <= state_d;
            redirect_q <= resolve & mispredict;
            if (resolve && mispredict) begin
                redirect_pc_q <= target;
            end
            if (resolve && (br_cnt_q != 32'hFFFF_FFFF)) begin
                br_cnt_q <= br_cnt_q + 32'd1;
            end
            if (resolve && mispredict && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
            if (resolve) begin
                bht_q[wr_idx] <= bht_next(bht_q[wr_idx], taken);
            end
        end
    end

    assign redirect    = redirect_q;
    assign flush_IF    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign br_cnt      = br_cnt_q;
    assign miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed cases plus a randomized run,
// with expected redirect/counter results queued at resolution and compared
// one cycle later.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_IF;
    logic        pred_taken_IF;
    logic        valid_ID;
    logic [2:0]  br_type_ID;
    logic        is_jal_ID;
    logic        opnd_ready_ID;
    logic [31:0] rs1_data, rs2_data, pc_ID, imm_ID;
    logic        pred_taken_ID;
    logic        stall_ID;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush_IF;
    logic [31:0] br_cnt, miss_cnt;

    always #5 clk = ~clk;

    branch_ctrl #(.BHT_IDX_W(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .pc_IF         (pc_IF),
        .pred_taken_IF (pred_taken_IF),
        .valid_ID      (valid_ID),
        .br_type_ID    (br_type_ID),
        .is_jal_ID     (is_jal_ID),
        .opnd_ready_ID (opnd_ready_ID),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .pc_ID         (pc_ID),
        .imm_ID        (imm_ID),
        .pred_taken_ID (pred_taken_ID),
        .stall_ID      (stall_ID),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .flush_IF      (flush_IF),
        .br_cnt        (br_cnt),
        .miss_cnt      (miss_cnt)
    );

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] br;
        logic [31:0] miss;
    } exp_t;

    exp_t        sb[$];
    logic [1:0]  bht_m [16];
    logic [31:0] br_m, miss_m;
    int          total = 0;
    int          bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) bht_m[i] = 2'b01;
        br_m   = 0;
        miss_m = 0;
        sb.delete();
    endtask

    function automatic logic ref_cmp(input logic [2:0] t, input logic [31:0] a,
                                     input logic [31:0] b);
        case (t)
            3'd1:    return a == b;
            3'd2:    return a != b;
            3'd3:    return $signed(a) < $signed(b);
            3'd4:    return a < b;
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic idle_inputs();
        valid_ID      = 1'b0;
        is_jal_ID     = 1'b0;
        br_type_ID    = 3'd0;
        opnd_ready_ID = 1'b0;
        pred_taken_ID = 1'b0;
    endtask

    // Drive one branch, hold operands not-ready for wait_cycles, resolve, and
    // check the registered results. Optional probe: a branch offered during the
    // FLUSH slot must be ignored.
    task automatic branch(input logic jal, input logic [2:0] typ, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                          input logic pred, input int wait_cycles, input bit flush_probe);
        logic       tk, miss;
        logic [3:0] idx;
        exp_t       e;
        valid_ID = 1'b1; is_jal_ID = jal; br_type_ID = typ;
        rs1_data = a; rs2_data = b; pc_ID = pc; imm_ID = imm;
        pred_taken_ID = pred; pc_IF = pc; opnd_ready_ID = 1'b0;
        for (int i = 0; i < wait_cycles; i++) begin
            #1 check_eq("stall_wait", stall_ID, 1);
            step();
        end
        opnd_ready_ID = 1'b1;
        #1 check_eq("stall_resolve", stall_ID, 0);
        idx = pc[5:2];
        check_eq("pred_if_pre", pred_taken_IF, bht_m[idx][1]);
        tk   = jal ? 1'b1 : ref_cmp(typ, a, b);
        miss = tk ^ pred;
        if (tk && bht_m[idx] != 2'b11) bht_m[idx] = bht_m[idx] + 2'b01;
        if (!tk && bht_m[idx] != 2'b00) bht_m[idx] = bht_m[idx] - 2'b01;
        br_m++;
        if (miss) miss_m++;
        e.redir = miss;
        e.rpc   = tk ? pc + imm : pc + 32'd4;
        e.br    = br_m;
        e.miss  = miss_m;
        sb.push_back(e);
        step();
        idle_inputs();
        e = sb.pop_front();
        check_eq("redirect", redirect, e.redir);
        check_eq("flush_IF", flush_IF, e.redir);
        if (e.redir) check_eq("redirect_pc", redirect_pc, e.rpc);
        check_eq("br_cnt", br_cnt, e.br);
        check_eq("miss_cnt", miss_cnt, e.miss);
        #1 check_eq("pred_if_post", pred_taken_IF, bht_m[idx][1]);
        if (e.redir) begin
            if (flush_probe) begin
                // would be a mispredicting BEQ if it were not ignored
                valid_ID = 1'b1; br_type_ID = 3'd1; rs1_data = 1; rs2_data = 2;
                pred_taken_ID = 1'b1; opnd_ready_ID = 1'b0;
                #1 check_eq("stall_flush", stall_ID, 0);
                opnd_ready_ID = 1'b1;
            end
            step();
            idle_inputs();
            check_eq("redirect_after_flush", redirect, 0);
            check_eq("br_cnt_after_flush", br_cnt, br_m);
        end
    endtask

    initial begin
        logic [31:0] a, b, pc;
        idle_inputs();
        rs1_data = 0; rs2_data = 0; pc_ID = 0; imm_ID = 0; pc_IF = 0;
        rst = 1'b1;
        model_reset();
        step();
        // stall must stay low while reset is held, even for a pending branch
        valid_ID = 1'b1; br_type_ID = 3'd1;
        #1 check_eq("stall_in_rst", stall_ID, 0);
        step();
        idle_inputs();
        rst = 1'b0;
        check_eq("rst_redirect", redirect, 0);
        check_eq("rst_flush", flush_IF, 0);
        check_eq("rst_rpc", redirect_pc, 0);
        check_eq("rst_br", br_cnt, 0);
        check_eq("rst_miss", miss_cnt, 0);
        pc_IF = 32'h3C;
        #1 check_eq("rst_bht15", pred_taken_IF, 0);

        // BEQ taken, predicted not-taken
        branch(1'b0, 3'd1, 5, 5, 32'h100, 32'h20, 1'b0, 0, 1'b1);
        // BLT signed -1 < 1: taken, predicted taken
        branch(1'b0, 3'd3, 32'hFFFF_FFFF, 1, 32'h204, 32'h40, 1'b1, 0, 1'b0);
        // BLTU unsigned: not taken, predicted taken -> pc+4
        branch(1'b0, 3'd4, 32'hFFFF_FFFF, 1, 32'h208, 32'h40, 1'b1, 0, 1'b0);
        // BNE with 3 stall cycles
        branch(1'b0, 3'd2, 7, 9, 32'h30C, 32'h10, 1'b1, 3, 1'b0);
        // JAL wrapping past 2^32
        branch(1'b1, 3'd0, 0, 0, 32'hFFFF_FFF0, 32'h20, 1'b0, 0, 1'b0);
        // Four taken at index 5: 01->10->11->11->11
        for (int i = 0; i < 4; i++) begin
            branch(1'b0, 3'd6, 10, 3, 32'h14, 32'h8, 1'b1, 0, 1'b0);
        end

        // Non-branch and reserved encodings: no stall, no effect
        for (int i = 0; i < 2; i++) begin
            valid_ID = 1'b1; br_type_ID = (i == 0) ? 3'd0 : 3'd7; opnd_ready_ID = 1'b0;
            pc_ID = 32'h14; pred_taken_ID = 1'b1;
            #1 check_eq("stall_nonbr", stall_ID, 0);
            opnd_ready_ID = 1'b1;
            step();
            idle_inputs();
            check_eq("redirect_nonbr", redirect, 0);
            check_eq("br_cnt_nonbr", br_cnt, br_m);
        end

        // Randomized branches
        for (int n = 0; n < 40; n++) begin
            a  = $urandom;
            b  = ($urandom_range(0, 1) == 1) ? a : $urandom;
            pc = $urandom & 32'hFFFF_FFFC;
            branch(($urandom_range(0, 7) == 0), 3'($urandom_range(1, 6)), a, b, pc,
                   $urandom, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 1'b0);
        end

        // Mispredict resolving with reset asserted
        valid_ID = 1'b1; br_type_ID = 3'd1; rs1_data = 4; rs2_data = 4;
        pc_ID = 32'h14; imm_ID = 32'h80; pred_taken_ID = 1'b0; opnd_ready_ID = 1'b1;
        rst = 1'b1;
        step();
        idle_inputs();
        rst = 1'b0;
        model_reset();
        check_eq("rstmiss_redirect", redirect, 0);
        check_eq("rstmiss_flush", flush_IF, 0);
        check_eq("rstmiss_br", br_cnt, 0);
        check_eq("rstmiss_miss", miss_cnt, 0);
        pc_IF = 32'h14;
        #1 check_eq("rstmiss_bht5", pred_taken_IF, 0);
        // BHT back to 01: one taken moves it to 10
        branch(1'b0, 3'd1, 4, 4, 32'h14, 32'h80, 1'b1, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
